// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data access; data wins by default.
// Define MEM_ARBITER_STARVE_EN to compile in the fetch starvation guard (wait counter, forced fetch win).
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} owner_t;

  owner_t            r_owner;
  owner_t            w_owner_nxt;
  logic              w_if_gnt;
  logic              w_dm_gnt;
  logic              w_starve;
  logic              w_if_rvalid;
  logic              w_dm_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("mem_arbiter: MAX_WAIT must be in 1..15");
  end

`ifdef MEM_ARBITER_STARVE_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  logic [3:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_wait_cnt <= '0;
    else if (w_if_gnt || !if_req)
      r_wait_cnt <= '0;
    else if (r_wait_cnt != MAX_WAIT_C)
      r_wait_cnt <= r_wait_cnt + 4'd1;
  end

  assign w_starve = if_req && (r_wait_cnt == MAX_WAIT_C);
`else
  assign w_starve = 1'b0;
`endif

  // Reset suppresses grants so a read requested during reset never returns data.
  assign w_dm_gnt = !rst && dm_req && !w_starve;
  assign w_if_gnt = !rst && if_req && !w_dm_gnt;

  assign w_if_rvalid = !rst && (r_owner == FETCH);
  assign w_dm_rvalid = !rst && (r_owner == DATA);

  always_ff @(posedge clk) begin
    if (rst)
      r_owner <= IDLE;
    else
      r_owner <= w_owner_nxt;
  end

  always_comb begin
    w_owner_nxt = IDLE;
    if (w_if_gnt)
      w_owner_nxt = FETCH;
    else if (w_dm_gnt && !dm_we)
      w_owner_nxt = DATA;
  end

  always_comb begin
    if_gnt    = w_if_gnt;
    dm_gnt    = w_dm_gnt;
    if_stall  = if_req && !w_if_gnt;
    mem_en    = w_if_gnt || w_dm_gnt;
    mem_we    = w_dm_gnt && dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_if_gnt) begin
      mem_addr = if_addr;
    end else if (w_dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
    if_rvalid = w_if_rvalid;
    dm_rvalid = w_dm_rvalid;
    if_rdata  = w_if_rvalid ? mem_rdata : r_if_rdata;
    dm_rdata  = w_dm_rvalid ? mem_rdata : r_dm_rdata;
    if (rst) begin
      if_rdata = '0;
      dm_rdata = '0;
    end
  end

  // Last returned word per side, shown while that side has nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_if_rvalid)
        r_if_rdata <= mem_rdata;
      if (w_dm_rvalid)
        r_dm_rdata <= mem_rdata;
    end
  end

endmodule
